systolic_array_nxn: RTL and testbench
=====================================

SYSTOLIC_ARRAY_NXN -- requirements
Module: systolic_array_nxn

Interface
REQ-001 Parameter N, default 4: array dimension (N x N PEs), legal range 2..8.
REQ-002 Parameter WIDTH, default 16: operand width, unsigned.
REQ-003 Parameter ACC_W, default 32: accumulator/result width, ACC_W >= WIDTH.
REQ-004 Parameter K, default 8: beats per operation (inner dimension), K >= 1.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  request a new operation; sampled only in IDLE.
REQ-008 acc_keep  in  1  sampled with start; 1 = keep accumulators (K-tiling), 0 = clear.
REQ-009 in_valid  in  1  west_data/north_data beat valid.
REQ-010 in_ready  out  1  array accepts a beat; beat transfers when in_valid & in_ready.
REQ-011 west_data  in  N*WIDTH  A column k; slice i feeds row i.
REQ-012 north_data  in  N*WIDTH  B row k; slice j feeds column j.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse; results valid.
REQ-015 result  out  N*N*ACC_W  C[i][j] at slice i*N+j.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; IDLE -> RUN on start; RUN -> DRAIN on K-th accepted beat; DRAIN -> DONE after count reaches 2N-1; DONE -> IDLE unconditionally.
REQ-017 in_ready shall be 1 exactly in RUN; in_valid outside RUN ignored.
REQ-018 Start acceptance edge: accumulators cleared to 0 if acc_keep=0, else held.
REQ-019 Internal skew: row i west input and column j north input delayed i and j cycles respectively, delay lines shifting every cycle in RUN and DRAIN.
REQ-020 Cycles in RUN without a transfer inject zero operands (bubble); result unaffected by stall pattern.
REQ-021 PE(i,j): acc += a*b, full 2*WIDTH product zero-extended/truncated to ACC_W, wrap modulo 2^ACC_W; a forwarded east, b south, one register each.
REQ-022 done shall be high exactly 2N cycles after the edge accepting the K-th beat; result[C[i][j]] = sum over k of A[i][k]*B[k][j] (mod 2^ACC_W), plus prior value when acc_keep=1.
REQ-023 result shall hold stable from done until the next start acceptance.
REQ-024 start while busy ignored; start and done never overlap (DONE returns to IDLE first).
REQ-025 Beat counter and drain counter sized $clog2 of max(K, 2N)+1; no wrap within one operation.

Reset
REQ-026 rst at any time, including mid-RUN/DRAIN: state IDLE, in_ready=0, busy=0, done=0, all accumulators, skew registers, PE pipeline registers and counters 0, result=0, next cycle.
REQ-027 rst dominates start and in_valid in the same cycle.

Structure
REQ-028 Package systolic_pkg: FSM state enum, function for drain length (2N-1), counter-width helper.
REQ-029 One sub-module systolic_pe (MAC + east/south forward registers, clear/hold inputs), generated N*N times; skew lines and FSM in the top.

Verification
REQ-030 N=2,K=2,WIDTH=8: A=[[1,2],[3,4]], B=[[5,6],[7,8]], in_valid continuous -> done 2N=4 cycles after last beat, result C=[[19,22],[43,50]].
REQ-031 Same data with in_valid deasserted 3 cycles between beats -> identical C, done 4 cycles after last accepted beat, in_ready high throughout RUN.
REQ-032 Two back-to-back ops, second with acc_keep=1 and same data -> C=[[38,44],[86,100]]; with acc_keep=0 -> [[19,22],[43,50]].
REQ-033 rst asserted mid-DRAIN -> next cycle busy=0, done never pulses, result=0; fresh start then yields correct C.
REQ-034 N=4,WIDTH=16,ACC_W=16,K=8, all operands 0xFFFF -> every C = (8*0xFFFE0001) mod 2^16 = 0x0008; wrap verified.
REQ-035 start pulsed in RUN and DONE -> ignored, single done pulse per accepted start.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the NxN systolic matrix-multiply array.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Cycles the pipeline needs after the last beat to reach the far corner PE.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int cnt_width(input int k, input int n);
        int m;
        m = (k > 2 * n) ? k : 2 * n;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/systolic_array_nxn_if.sv
// Operation control, operand beat stream and result bus of the systolic array.
interface systolic_array_nxn_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int ACC_W = 32
);
    logic                   start;
    logic                   acc_keep;
    logic                   in_valid;
    logic                   in_ready;
    logic [N*WIDTH-1:0]     west_data;
    logic [N*WIDTH-1:0]     north_data;
    logic                   busy;
    logic                   done;
    logic [N*N*ACC_W-1:0]   result;

    modport master (
        output start, acc_keep, in_valid, west_data, north_data,
        input  in_ready, busy, done, result
    );

    modport slave (
        input  start, acc_keep, in_valid, west_data, north_data,
        output in_ready, busy, done, result
    );
endinterface

// File: rtl/systolic_pe.sv
// Processing element: unsigned MAC into a wrapping accumulator, forwards a east and b south.
// Latency: one register on each forward path; accumulator updates on the same edge.
// Backpressure: none; en freezes all state, clr zeroes the accumulator.
module systolic_pe #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [ACC_W-1:0] acc
);
    logic [2*WIDTH-1:0] prod;

    assign prod = (2*WIDTH)'(a_in) * (2*WIDTH)'(b_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (en)
                acc <= acc + ACC_W'(prod);
            if (en) begin
                a_out <= a_in;
                b_out <= b_in;
            end
        end
    end
endmodule

// File: rtl/systolic_array_nxn.sv
// NxN output-stationary systolic array computing C = A*B over K operand beats.
// Latency: done pulses 2N cycles after the edge accepting the K-th beat.
// Backpressure: in_ready only in RUN; idle RUN cycles inject zero bubbles.
module systolic_array_nxn
    import systolic_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int ACC_W = 32,
    parameter int K     = 8
) (
    input  logic               clk,
    input  logic               rst,
    systolic_array_nxn_if.slave bus
);
    localparam int                CNT_W     = cnt_width(K, N);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0]  DRAIN_END = CNT_W'(drain_len(N));

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             active;
    logic             xfer;
    logic             clr;

    wire  [WIDTH-1:0] a_h   [N][N+1];
    wire  [WIDTH-1:0] b_v   [N+1][N];
    wire  [ACC_W-1:0] acc_q [N][N];

    assign run    = (state == ST_RUN);
    assign active = run || (state == ST_DRAIN);
    assign xfer   = bus.in_valid && run;
    assign clr    = (state == ST_IDLE) && bus.start && !bus.acc_keep;

    assign bus.in_ready = run;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);

    // One counter serves as beat count in RUN and drain count in DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (bus.start)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (cnt == LAST_BEAT) begin
                            state <= ST_DRAIN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt == DRAIN_END) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Row i / column i edge inputs are delayed i cycles so matching a/b meet in each PE.
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic [WIDTH-1:0] w_inj;
        logic [WIDTH-1:0] n_inj;

        assign w_inj = xfer ? bus.west_data[i*WIDTH +: WIDTH]  : '0;
        assign n_inj = xfer ? bus.north_data[i*WIDTH +: WIDTH] : '0;

        if (i == 0) begin : g_direct
            assign a_h[0][0] = w_inj;
            assign b_v[0][0] = n_inj;
        end else begin : g_delay
            logic [WIDTH-1:0] w_sr [i];
            logic [WIDTH-1:0] n_sr [i];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < i; d++) begin
                        w_sr[d] <= '0;
                        n_sr[d] <= '0;
                    end
                end else if (active) begin
                    w_sr[0] <= w_inj;
                    n_sr[0] <= n_inj;
                    for (int d = 1; d < i; d++) begin
                        w_sr[d] <= w_sr[d-1];
                        n_sr[d] <= n_sr[d-1];
                    end
                end
            end

            assign a_h[i][0] = w_sr[i-1];
            assign b_v[0][i] = n_sr[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            systolic_pe #(
                .WIDTH (WIDTH),
                .ACC_W (ACC_W)
            ) u_pe (
                .clk   (clk),
                .rst   (rst),
                .en    (active),
                .clr   (clr),
                .a_in  (a_h[i][j]),
                .b_in  (b_v[i][j]),
                .a_out (a_h[i][j+1]),
                .b_out (b_v[i+1][j]),
                .acc   (acc_q[i][j])
            );

            assign bus.result[(i*N+j)*ACC_W +: ACC_W] = acc_q[i][j];
        end
    end
endmodule

// File: tb/tb_systolic_array_nxn.sv
// Directed self-checking bench: 2x2 (8-bit, K=2) functional cases and a 4x4 16-bit wrap case.
module tb_systolic_array_nxn;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    systolic_array_nxn_if #(.N(2), .WIDTH(8),  .ACC_W(32)) m2 ();
    systolic_array_nxn_if #(.N(4), .WIDTH(16), .ACC_W(16)) m4 ();

    systolic_array_nxn #(.N(2), .WIDTH(8), .ACC_W(32), .K(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (m2.slave)
    );

    systolic_array_nxn #(.N(4), .WIDTH(16), .ACC_W(16), .K(8)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (m4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A=[[1,2],[3,4]], B=[[5,6],[7,8]]: beat k carries A column k and B row k.
    localparam logic [15:0] W2 [2] = '{16'h0301, 16'h0402};
    localparam logic [15:0] N2 [2] = '{16'h0605, 16'h0807};
    localparam int          C2 [2][2] = '{'{19, 22}, '{43, 50}};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op2(input logic keep, input int gap, input logic poke, input int mult,
                       input string tag);
        int lat;
        int pulses;
        m2.start    = 1'b1;
        m2.acc_keep = keep;
        @(negedge clk);
        m2.start    = poke;
        m2.acc_keep = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m2.in_valid   = 1'b1;
            m2.west_data  = W2[k];
            m2.north_data = N2[k];
            chk({tag, "_rdy_beat"}, 64'(m2.in_ready), 64'd1);
            @(negedge clk);
            m2.in_valid = 1'b0;
            m2.start    = 1'b0;
            if (k == 0) begin
                for (int g = 0; g < gap; g++) begin
                    chk({tag, "_rdy_gap"}, 64'(m2.in_ready), 64'd1);
                    @(negedge clk);
                end
            end
        end
        lat = 0;
        while (m2.done !== 1'b1 && lat < 20) begin
            if (poke) begin
                m2.in_valid   = 1'b1;
                m2.west_data  = '1;
                m2.north_data = '1;
            end
            @(negedge clk);
            lat++;
        end
        m2.in_valid = 1'b0;
        chk({tag, "_done_lat"}, 64'(lat), 64'd4);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                chk($sformatf("%s_c%0d%0d", tag, i, j),
                    64'(m2.result[(i*2+j)*32 +: 32]), 64'(mult * C2[i][j]));
        if (poke) m2.start = 1'b1;
        @(negedge clk);
        m2.start = 1'b0;
        chk({tag, "_done_pulse"}, 64'(m2.done), 64'd0);
        chk({tag, "_idle"}, 64'(m2.busy), 64'd0);
        if (poke) begin
            pulses = 0;
            repeat (6) begin
                @(negedge clk);
                if (m2.done) pulses++;
            end
            chk({tag, "_no_extra_done"}, 64'(pulses), 64'd0);
            chk({tag, "_still_idle"}, 64'(m2.busy), 64'd0);
        end
    endtask

    initial begin
        int lat;
        int pulses;
        total         = 0;
        passed        = 0;
        rst           = 1'b1;
        m2.start      = 1'b0;
        m2.acc_keep   = 1'b0;
        m2.in_valid   = 1'b0;
        m2.west_data  = '0;
        m2.north_data = '0;
        m4.start      = 1'b0;
        m4.acc_keep   = 1'b0;
        m4.in_valid   = 1'b0;
        m4.west_data  = '0;
        m4.north_data = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy",     64'(m2.busy),        64'd0);
        chk("rst_ready",    64'(m2.in_ready),    64'd0);
        chk("rst_done",     64'(m2.done),        64'd0);
        chk("rst_result",   64'(m2.result == '0), 64'd1);
        chk("rst_busy4",    64'(m4.busy),        64'd0);
        chk("rst_result4",  64'(m4.result == '0), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready",   64'(m2.in_ready),    64'd0);

        op2(1'b0, 0, 1'b0, 1, "cont");
        op2(1'b0, 3, 1'b0, 1, "stall");
        op2(1'b1, 0, 1'b0, 2, "keep");
        op2(1'b0, 0, 1'b0, 1, "clear");

        // Reset in the middle of DRAIN.
        m2.start = 1'b1;
        @(negedge clk);
        m2.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m2.in_valid   = 1'b1;
            m2.west_data  = W2[k];
            m2.north_data = N2[k];
            @(negedge clk);
        end
        m2.in_valid = 1'b0;
        @(negedge clk);
        chk("drain_busy", 64'(m2.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy",   64'(m2.busy),         64'd0);
        chk("mid_rst_ready",  64'(m2.in_ready),     64'd0);
        chk("mid_rst_result", 64'(m2.result == '0), 64'd1);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (m2.done) pulses++;
        end
        chk("mid_rst_no_done", 64'(pulses), 64'd0);
        op2(1'b0, 0, 1'b0, 1, "post_rst");

        op2(1'b0, 1, 1'b1, 1, "poke");

        // 4x4 wrap: 8 * 0xFFFF*0xFFFF mod 2^16 = 8.
        m4.start    = 1'b1;
        m4.acc_keep = 1'b0;
        @(negedge clk);
        m4.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m4.in_valid   = 1'b1;
            m4.west_data  = '1;
            m4.north_data = '1;
            @(negedge clk);
        end
        m4.in_valid = 1'b0;
        lat = 0;
        while (m4.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("wrap_done_lat", 64'(lat), 64'd8);
        for (int e = 0; e < 16; e++)
            chk($sformatf("wrap_c%0d", e), 64'(m4.result[e*16 +: 16]), 64'h0008);
        @(negedge clk);
        chk("wrap_idle", 64'(m4.busy), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
